mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller; the consumer end of the EX/MEM pipeline register.
//  Takes the latched access flags, byte select, address (result) and store data.
//  Runs a req/ack transaction on the data-RAM bus and stalls the pipeline until it retires.
//  Returns lane-aligned, sign/zero-extended load data to the MEM/WB path.
// PARAMETERS
//  DATA_W  32  data bus width (`DATA_BUS_WIDTH)
//  ADDR_W  32  address width (`ADDR_BUS_WIDTH)
//  SEL_W   4   byte-lane select width (`MEM_SEL_BUS_WIDTH)
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset: synchronous, active-low
//  flush          in   1       pipeline flush (exception/eret)
//  mem_read_flag  in   1       load in MEM
//  mem_write_flag in   1       store in MEM
//  mem_sign_ext   in   1       1 = sign-extend load; 0 = zero-extend
//  mem_sel        in   SEL_W   byte lanes, already positioned by addr[1:0]
//  mem_addr       in   ADDR_W  EX result (effective address)
//  mem_wdata      in   DATA_W  raw rt value for stores
//  ram_req        out  1       bus request; held until ram_ack
//  ram_we         out  1       1 = write
//  ram_addr       out  ADDR_W  {mem_addr[ADDR_W-1:2],2'b00}
//  ram_sel        out  SEL_W   byte enables
//  ram_wdata      out  DATA_W  lane-replicated store data
//  ram_rdata      in   DATA_W  read data, valid with ram_ack
//  ram_ack        in   1       transaction complete (1 cycle)
//  stall_req      out  1       hold EX/MEM and all earlier stages
//  load_data      out  DATA_W  aligned/extended load result
//  mem_done       out  1       1-cycle pulse: access retired, load_data valid
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; ram_req, ram_we, mem_done, aborted = 0.
//   ram_addr, ram_sel, ram_wdata, load_data = 0. A bus transaction in flight is dropped.
//   The RAM slave shares this reset.
//  FSM IDLE -> ACCESS -> DONE -> IDLE. access = (read|write) & ~flush.
//   IDLE: if access, register addr/sel/we/wdata, set ram_req, go ACCESS. stall_req = access (combinational).
//   ACCESS: ram_req=1, bus fields frozen, stall_req=1.
//    On ram_ack: ram_req=0 next cycle; capture ram_rdata if read; go DONE.
//   DONE: stall_req=0, mem_done=1 (unless aborted); go IDLE unconditionally, with no relaunch.
//    The EX/MEM contents still belong to the retired instruction in this cycle.
//  Latency: stall_req high for 1+N cycles, N = cycles ram_req is high, ack cycle included.
//   The minimum is 2 (ack in the first ACCESS cycle).
//  Flush in IDLE: no launch, stall_req=0. Flush in ACCESS: the bus is not abortable.
//   ram_req stays high until ack, stall_req stays 1, and aborted is set.
//   DONE then suppresses mem_done and leaves load_data unchanged; aborted clears on IDLE entry.
//  read & write together: treated as write.
//  Store data: sel 1111 -> wdata; 0011/1100 -> {2{wdata[15:0]}};
//   single lane -> {4{wdata[7:0]}}.
//  Load extract on the captured word: 0001/0010/0100/1000 -> bytes 0..3; 0011 -> [15:0]; 1100 -> [31:16];
//   1111 -> word. Any other sel -> 0. Extend to DATA_W per mem_sign_ext.
// CONFIGURATION
//  ADDR_ALIGN_CHECK_EN defined: adds outputs addr_err_load, addr_err_store (1 bit each).
//   An illegal sel/addr[1:0] pair (half with addr[0]=1, word with addr[1:0]!=0, sel not matching lane)
//   suppresses the launch. stall_req=0 and the matching err flag is high combinationally in that IDLE cycle.
//  Not defined: no check, no ports; every access launches as given.
// STRUCTURE
//  bus.v: MEM_SEL lane pattern macros (SEL_BYTE0..3, SEL_HALF_LO/HI, SEL_WORD), widths.
//  Local localparams: FSM state encoding (2 bits).
//  Sub-module: mem_load_align (combinational extract + extend); instantiated once.
// TESTING
//  1 Word load addr 0x100, sel 1111, ack 3 cycles after req, rdata 0x8899AABB:
//    ram_addr 0x100, stall_req 4 cycles, mem_done with load_data 0x8899AABB.
//  2 Byte load sel 0100, rdata 0x00F30000: sign_ext=1 -> 0xFFFFFFF3; sign_ext=0 -> 0x000000F3.
//  3 Half store sel 1100, wdata 0x1234ABCD, addr 0x206:
//    ram_we 1, ram_addr 0x204, ram_sel 1100, ram_wdata 0xABCDABCD.
//  4 Flush in second ACCESS cycle, ack 2 cycles later:
//    ram_req held to ack, no mem_done, load_data keeps its prior value.
//  5 rst=0 mid-ACCESS: next cycle ram_req 0, stall_req 0, state IDLE, all outputs 0.
//  6 ADDR_ALIGN_CHECK_EN, word load addr 0x102, sel 1111:
//    no ram_req, addr_err_load 1 for one cycle, stall_req 0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared widths, FSM states, lane patterns and lane helpers
package mem_access_ctrl_pkg;

  localparam int DATA_BUS_WIDTH    = 32;
  localparam int ADDR_BUS_WIDTH    = 32;
  localparam int MEM_SEL_BUS_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  localparam logic [3:0] SEL_BYTE0   = 4'b0001;
  localparam logic [3:0] SEL_BYTE1   = 4'b0010;
  localparam logic [3:0] SEL_BYTE2   = 4'b0100;
  localparam logic [3:0] SEL_BYTE3   = 4'b1000;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  // Replicate the low byte/half of the store value across every lane so the
  // enabled lanes see the right bytes whatever the offset.
  function automatic logic [31:0] store_lanes(input logic [3:0] sel, input logic [31:0] wdata);
    case (sel)
      SEL_WORD:                                   return wdata;
      SEL_HALF_LO, SEL_HALF_HI:                   return {2{wdata[15:0]}};
      SEL_BYTE0, SEL_BYTE1, SEL_BYTE2, SEL_BYTE3: return {4{wdata[7:0]}};
      default:                                    return wdata;
    endcase
  endfunction

  // 1 when the lane pattern does not match the byte offset of the address.
  function automatic logic sel_misaligned(input logic [3:0] sel, input logic [1:0] addr_lo);
    case (sel)
      SEL_BYTE0:   return addr_lo != 2'd0;
      SEL_BYTE1:   return addr_lo != 2'd1;
      SEL_BYTE2:   return addr_lo != 2'd2;
      SEL_BYTE3:   return addr_lo != 2'd3;
      SEL_HALF_LO: return addr_lo != 2'd0;
      SEL_HALF_HI: return addr_lo != 2'd2;
      SEL_WORD:    return addr_lo != 2'd0;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-RAM req/ack bus between the MEM stage and the RAM slave
// Signals:
//   ram_req   master->slave  request, held until ram_ack
//   ram_we    master->slave  1 = write
//   ram_addr  master->slave  word-aligned address
//   ram_sel   master->slave  byte enables
//   ram_wdata master->slave  lane-replicated store data
//   ram_rdata slave->master  read data, valid with ram_ack
//   ram_ack   slave->master  one-cycle completion
interface mem_access_ctrl_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_WIDTH,
  parameter int ADDR_W = ADDR_BUS_WIDTH,
  parameter int SEL_W  = MEM_SEL_BUS_WIDTH
);
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [SEL_W-1:0]  ram_sel;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport master (
    output ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - combinational load lane extract and sign/zero extend
// Ports:
//   word     in   raw RAM word
//   sel      in   byte-lane pattern of the load
//   sign_ext in   1 = sign-extend, 0 = zero-extend
//   data     out  aligned, extended load value (0 for an unknown pattern)
module mem_load_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_WIDTH,
  parameter int SEL_W  = MEM_SEL_BUS_WIDTH
) (
  input  logic [DATA_W-1:0] word,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data
);
  always_comb begin
    data = '0;
    case (sel)
      SEL_BYTE0:   data = {{(DATA_W-8){sign_ext & word[7]}},   word[7:0]};
      SEL_BYTE1:   data = {{(DATA_W-8){sign_ext & word[15]}},  word[15:8]};
      SEL_BYTE2:   data = {{(DATA_W-8){sign_ext & word[23]}},  word[23:16]};
      SEL_BYTE3:   data = {{(DATA_W-8){sign_ext & word[31]}},  word[31:24]};
      SEL_HALF_LO: data = {{(DATA_W-16){sign_ext & word[15]}}, word[15:0]};
      SEL_HALF_HI: data = {{(DATA_W-16){sign_ext & word[31]}}, word[31:16]};
      SEL_WORD:    data = word;
      default:     data = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access controller (IDLE/ACCESS/DONE)
// Optional build macro: ADDR_ALIGN_CHECK_EN adds addr_err_load/addr_err_store and
// blocks launch of misaligned accesses.
// Ports:
//   clk, rst (sync, active-low), flush
//   mem_read_flag, mem_write_flag, mem_sign_ext, mem_sel, mem_addr, mem_wdata  EX/MEM inputs
//   ram        master side of the data-RAM bus
//   stall_req  hold EX/MEM and earlier stages
//   load_data  aligned/extended load result (held between loads)
//   mem_done   one-cycle pulse when an unflushed access retires
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_WIDTH,
  parameter int ADDR_W = ADDR_BUS_WIDTH,
  parameter int SEL_W  = MEM_SEL_BUS_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  mem_access_ctrl_if.master ram,
  output logic              stall_req,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_done
`ifdef ADDR_ALIGN_CHECK_EN
  ,
  output logic              addr_err_load,
  output logic              addr_err_store
`endif
);
  state_t            state, state_nx;
  logic              access, illegal, launch;
  logic              req_c;
  logic              we_q, sign_q, aborted;
  logic [ADDR_W-1:0] addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] wdata_q, load_q, load_aligned;

  assign access = (mem_read_flag | mem_write_flag) & ~flush;

`ifdef ADDR_ALIGN_CHECK_EN
  assign illegal        = sel_misaligned(mem_sel, mem_addr[1:0]);
  // read & write together counts as a store
  assign addr_err_store = (state == ST_IDLE) & access & mem_write_flag & illegal;
  assign addr_err_load  = (state == ST_IDLE) & access & ~mem_write_flag & illegal;
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^mem_addr[1:0];
  assign illegal        = 1'b0;
`endif

  assign launch = access & ~illegal;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (launch) state_nx = ST_ACCESS;
      ST_ACCESS: if (ram.ram_ack) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_c     = 1'b0;
    stall_req = 1'b0;
    mem_done  = 1'b0;
    case (state)
      ST_IDLE:   stall_req = launch;
      ST_ACCESS: begin
        req_c     = 1'b1;
        stall_req = 1'b1;
      end
      ST_DONE:   mem_done = ~aborted;
      default:   ;
    endcase
  end

  mem_load_align #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_load_align (
    .word     (ram.ram_rdata),
    .sel      (sel_q),
    .sign_ext (sign_q),
    .data     (load_aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      aborted <= 1'b0;
    end else begin
      if (state == ST_IDLE && launch) begin
        we_q    <= mem_write_flag;
        sign_q  <= mem_sign_ext;
        addr_q  <= {mem_addr[ADDR_W-1:2], 2'b00};
        sel_q   <= mem_sel;
        wdata_q <= store_lanes(mem_sel, mem_wdata);
      end
      // The bus cannot be cancelled, so a flush only marks the access as dead.
      if (state == ST_ACCESS && flush) aborted <= 1'b1;
      else if (state == ST_DONE)       aborted <= 1'b0;
      // Load data is taken at the ack edge so it is valid alongside mem_done;
      // a flush on the ack cycle itself also discards it.
      if (state == ST_ACCESS && ram.ram_ack && !we_q && !(aborted | flush))
        load_q <= load_aligned;
    end
  end

  assign ram.ram_req   = req_c;
  assign ram.ram_we    = we_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_sel   = sel_q;
  assign ram.ram_wdata = wdata_q;
  assign load_data     = load_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush, mem_read_flag, mem_write_flag, mem_sign_ext;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic        stall_req, mem_done;
`ifdef ADDR_ALIGN_CHECK_EN
  logic        addr_err_load, addr_err_store;
`endif

  mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32), .SEL_W(4)) bus ();

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .SEL_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .mem_read_flag  (mem_read_flag),
    .mem_write_flag (mem_write_flag),
    .mem_sign_ext   (mem_sign_ext),
    .mem_sel        (mem_sel),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .ram            (bus),
    .stall_req      (stall_req),
    .load_data      (load_data),
    .mem_done       (mem_done)
`ifdef ADDR_ALIGN_CHECK_EN
    ,
    .addr_err_load  (addr_err_load),
    .addr_err_store (addr_err_store)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  int          stall_q[$];
  logic [31:0] done_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_load = 32'h0;
  int          tx_delay = 1;
  logic [31:0] tx_rdata = 32'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int sel_low(input logic [3:0] sel);
    int lo = 0;
    while (lo < 4 && sel[lo] == 1'b0) lo++;
    return lo;
  endfunction

  // Reference: a legal pattern is n contiguous lanes (n = 1, 2 or 4) starting at a multiple of n.
  function automatic bit sel_legal(input logic [3:0] sel);
    int n  = $countones(sel);
    int lo = sel_low(sel);
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    if (sel != 4'(((1 << n) - 1) << lo)) return 1'b0;
    return (lo % n) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] sel, input logic [31:0] rdata, input bit sgn);
    int          bits;
    logic [31:0] v, mask;
    if (!sel_legal(sel)) return 32'h0;
    bits = 8 * $countones(sel);
    v    = rdata >> (8 * sel_low(sel));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v    = v & mask;
      if (sgn && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [3:0] sel, input logic [31:0] wdata);
    int          bits;
    logic [31:0] r, chunk;
    if (!sel_legal(sel) || $countones(sel) == 4) return wdata;
    bits  = 8 * $countones(sel);
    chunk = wdata & ((32'd1 << bits) - 32'd1);
    r     = 32'h0;
    for (int i = 0; i < 32 / bits; i++) r = r | (chunk << (bits * i));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after a rising edge with the DUT in IDLE.
  task automatic run_tx(input bit rd, input bit wr, input bit sgn, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int d, input int flush_at);
    bus_exp_t e;
    e.we    = wr;
    e.addr  = addr & 32'hFFFF_FFFC;
    e.sel   = sel;
    e.wdata = model_store(sel, wdata);
    bus_q.push_back(e);
    stall_q.push_back(1 + d);
    if (flush_at == 0) begin
      if (rd && !wr) exp_load = model_load(sel, rdata, sgn);
      done_q.push_back(exp_load);
    end
    tx_delay       = d;
    tx_rdata       = rdata;
    mem_read_flag  = rd;
    mem_write_flag = wr;
    mem_sign_ext   = sgn;
    mem_sel        = sel;
    mem_addr       = addr;
    mem_wdata      = wdata;
    for (int c = 1; c <= d; c++) begin
      step();
      flush = (c == flush_at);
    end
    step();
    flush = 1'b0;
    step();
    mem_read_flag  = 1'b0;
    mem_write_flag = 1'b0;
  endtask

  // RAM slave: ack in the d-th cycle that ram_req is seen high.
  initial begin
    int cnt;
    cnt = 0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ram_req === 1'b1) begin
        cnt++;
        bus.ram_ack   = (cnt == tx_delay);
        bus.ram_rdata = (cnt == tx_delay) ? tx_rdata : $urandom;
      end else begin
        cnt         = 0;
        bus.ram_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents something.
  initial begin
    bit       req_prev;
    int       run;
    bus_exp_t e;
    logic [31:0] ld;
    int       st;
    req_prev = 1'b0;
    run      = 0;
    forever begin
      @(negedge clk);
      if (bus.ram_req === 1'b1 && !req_prev) begin
        check("req_pending", 32'(bus_q.size()), 32'd1);
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          check("ram_we", 32'(bus.ram_we), 32'(e.we));
          check("ram_addr", bus.ram_addr, e.addr);
          check("ram_sel", 32'(bus.ram_sel), 32'(e.sel));
          if (e.we) check("ram_wdata", bus.ram_wdata, e.wdata);
        end
      end
      req_prev = (bus.ram_req === 1'b1);
      if (stall_req === 1'b1) run++;
      else if (run > 0) begin
        check("stall_pending", 32'(stall_q.size()), 32'd1);
        if (stall_q.size() > 0) begin
          st = stall_q.pop_front();
          check("stall_len", 32'(run), 32'(st));
        end
        run = 0;
      end
      if (mem_done === 1'b1) begin
        check("done_pending", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) begin
          ld = done_q.pop_front();
          check("load_data", load_data, ld);
        end
      end
    end
  end

  initial begin
    logic [3:0] sels[7];
    logic [3:0] sel;
    logic [31:0] addr;
    int op, d, fa;
    bus_exp_t e;
    sels = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    rst = 1'b0; flush = 1'b0; mem_read_flag = 1'b0; mem_write_flag = 1'b0;
    mem_sign_ext = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_ram_req", 32'(bus.ram_req), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_done", 32'(mem_done), 32'd0);
    check("rst_load", load_data, 32'h0);
    check("rst_addr", bus.ram_addr, 32'h0);
    check("rst_wdata", bus.ram_wdata, 32'h0);
    step();

    run_tx(1, 0, 0, 4'b1111, 32'h100, 32'h0, 32'h8899AABB, 3, 0);
    check("t1_addr", bus.ram_addr, 32'h100);
    check("t1_load", load_data, 32'h8899AABB);
    run_tx(1, 0, 1, 4'b0100, 32'h302, 32'h0, 32'h00F30000, 1, 0);
    check("t2_sext", load_data, 32'hFFFFFFF3);
    run_tx(1, 0, 0, 4'b0100, 32'h302, 32'h0, 32'h00F30000, 2, 0);
    check("t2_zext", load_data, 32'h000000F3);
    run_tx(0, 1, 0, 4'b1100, 32'h206, 32'h1234ABCD, 32'h0, 2, 0);
    check("t3_we", 32'(bus.ram_we), 32'd1);
    check("t3_addr", bus.ram_addr, 32'h204);
    check("t3_sel", 32'(bus.ram_sel), 32'hC);
    check("t3_wdata", bus.ram_wdata, 32'hABCDABCD);
    run_tx(1, 0, 0, 4'b1111, 32'h0, 32'h0, 32'hDEADBEEF, 4, 2);
    check("t4_load_kept", load_data, 32'h000000F3);

    // Reset in the second ACCESS cycle.
    e.we = 1'b0; e.addr = 32'h400; e.sel = 4'hF; e.wdata = 32'h0;
    bus_q.push_back(e);
    stall_q.push_back(3);
    tx_delay = 4;
    mem_read_flag = 1'b1; mem_sel = 4'hF; mem_addr = 32'h400; mem_wdata = 32'h0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mem_read_flag = 1'b0;
    exp_load = 32'h0;
    @(negedge clk);
    check("t5_ram_req", 32'(bus.ram_req), 32'd0);
    check("t5_stall", 32'(stall_req), 32'd0);
    check("t5_load", load_data, 32'h0);
    check("t5_sel", 32'(bus.ram_sel), 32'h0);
    check("t5_addr", bus.ram_addr, 32'h0);
    step();

`ifdef ADDR_ALIGN_CHECK_EN
    mem_read_flag = 1'b1; mem_sel = 4'hF; mem_addr = 32'h102;
    @(negedge clk);
    check("t6_err_load", 32'(addr_err_load), 32'd1);
    check("t6_err_store", 32'(addr_err_store), 32'd0);
    check("t6_stall", 32'(stall_req), 32'd0);
    step();
    mem_read_flag = 1'b0;
    @(negedge clk);
    check("t6_err_clear", 32'(addr_err_load), 32'd0);
    check("t6_no_req", 32'(bus.ram_req), 32'd0);
    step();
`endif

    for (int t = 0; t < 60; t++) begin
      op  = int'($urandom_range(0, 2));
      sel = sels[$urandom_range(0, 6)];
`ifndef ADDR_ALIGN_CHECK_EN
      if (op == 0 && $urandom_range(0, 9) == 0) sel = 4'($urandom_range(0, 15));
`endif
      addr = $urandom;
`ifdef ADDR_ALIGN_CHECK_EN
      addr[1:0] = 2'(sel_low(sel));
`endif
      d  = int'($urandom_range(1, 4));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, d)) : 0;
      run_tx(op != 1, op != 0, 1'($urandom_range(0, 1)), sel, addr, $urandom, $urandom, d, fa);
      if ($urandom_range(0, 4) == 0) begin
        mem_read_flag = 1'b1; mem_sel = 4'hF; mem_addr = 32'h0; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", 32'(stall_req), 32'd0);
        step();
        flush = 1'b0; mem_read_flag = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("stall_q_empty", 32'(stall_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
